// File: rtl/bcd_conv_pkg.sv
// Shared types and constants for the sequential BCD-to-binary converter.
// Optional digit range checking is enabled by defining BCD_ERR_CHECK_EN.
package bcd_conv_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int          BCD_DIGIT_W   = 4;
  localparam logic [3:0]  BCD_MAX_DIGIT = 4'd9;

  // Smallest result width that holds every value of a 'digits'-digit decimal word.
  function automatic int bin_w_for(input int digits);
    longint unsigned p;
    p = 1;
    for (int i = 0; i < digits; i++) begin
      p = p * 10;
    end
    return $clog2(p);
  endfunction

endpackage

// File: rtl/bcd_mac10.sv
// Combinational multiply-by-10-and-add step: acc_o = acc_i*10 + d_i, modulo 2^BIN_W.
// Built from two ripple-carry chains: (acc<<3)+(acc<<1), then + digit.
module bcd_mac10
  import bcd_conv_pkg::*;
#(
  parameter int BIN_W = 14
) (
  input  logic [BIN_W-1:0]       acc_i,
  input  logic [BCD_DIGIT_W-1:0] d_i,
  output logic [BIN_W-1:0]       acc_o
);

  // The result is truncated to BIN_W, and carries only flow upward, so bits
  // above BIN_W can never influence the kept bits and are not built.
  logic [BIN_W-1:0] x8;
  logic [BIN_W-1:0] x2;
  logic [BIN_W-1:0] dz;
  logic [BIN_W-1:0] s1;
  logic [BIN_W-1:0] s2;
  logic [BIN_W-1:0] c1;
  logic [BIN_W-1:0] c2;

  assign x8 = acc_i << 3;
  assign x2 = acc_i << 1;
  assign dz = {{(BIN_W-BCD_DIGIT_W){1'b0}}, d_i};

  assign c1[0] = 1'b0;
  assign c2[0] = 1'b0;

  for (genvar i = 0; i < BIN_W; i++) begin : g_ripple
    assign s1[i] = x8[i] ^ x2[i] ^ c1[i];
    assign s2[i] = s1[i] ^ dz[i] ^ c2[i];
    if (i < BIN_W - 1) begin : g_carry
      assign c1[i+1] = (x8[i] & x2[i]) | (c1[i] & (x8[i] ^ x2[i]));
      assign c2[i+1] = (s1[i] & dz[i]) | (c2[i] & (s1[i] ^ dz[i]));
    end
  end

  assign acc_o = s2;

endmodule

// File: rtl/bcd_binary_seq_ctrl.sv
// Sequential multi-digit BCD-to-binary converter with valid/ready in and out.
// Define BCD_ERR_CHECK_EN to flag any digit above 9 on the err output.
module bcd_binary_seq_ctrl
  import bcd_conv_pkg::*;
#(
  parameter int DIGITS = 4,
  parameter int BIN_W  = 14
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [BCD_DIGIT_W*DIGITS-1:0] bcd_in,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [BIN_W-1:0]              bin_out,
  output logic                          err
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high; a producer holds valid and data stable until that edge.
  localparam int SR_W  = BCD_DIGIT_W * DIGITS;
  localparam int CNT_W = $clog2(DIGITS);

  state_t                   state;
  logic [SR_W-1:0]          sreg;
  logic [BIN_W-1:0]         acc;
  logic [CNT_W-1:0]         cnt;
  logic [BCD_DIGIT_W-1:0]   digit;
  logic [BIN_W-1:0]         acc_next;

  assign digit = sreg[SR_W-1 -: BCD_DIGIT_W];

  bcd_mac10 #(.BIN_W(BIN_W)) u_mac10 (
    .acc_i (acc),
    .d_i   (digit),
    .acc_o (acc_next)
  );

`ifdef BCD_ERR_CHECK_EN
  logic err_l;
  logic err_r;
  logic digit_bad;

  assign digit_bad = (digit > BCD_MAX_DIGIT);
  assign err       = err_r;

  always_ff @(posedge clk) begin
    if (rst) begin
      err_l <= 1'b0;
      err_r <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) err_l <= 1'b0;
        CONV: begin
          err_l <= err_l | digit_bad;
          if (cnt == CNT_W'(DIGITS - 1)) err_r <= err_l | digit_bad;
        end
        default: ;
      endcase
    end
  end
`else
  assign err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      bin_out   <= '0;
      acc       <= '0;
      cnt       <= '0;
      sreg      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            sreg     <= bcd_in;
            acc      <= '0;
            cnt      <= '0;
            in_ready <= 1'b0;
            state    <= CONV;
          end
        end
        CONV: begin
          acc  <= acc_next;
          sreg <= {sreg[SR_W-BCD_DIGIT_W-1:0], {BCD_DIGIT_W{1'b0}}};
          cnt  <= cnt + CNT_W'(1);
          if (cnt == CNT_W'(DIGITS - 1)) begin
            bin_out   <= acc_next;
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_binary_seq_ctrl.sv
// Directed bench for bcd_binary_seq_ctrl: a 4-digit and a 2-digit instance.
module tb_bcd_binary_seq_ctrl;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] bcd_in;
  logic        out_valid;
  logic        out_ready;
  logic [13:0] bin_out;
  logic        err;

  logic        in_valid2;
  logic        in_ready2;
  logic [7:0]  bcd_in2;
  logic        out_valid2;
  logic        out_ready2;
  logic [6:0]  bin_out2;
  logic        err2;

  int errors = 0;
  int checks = 0;
  logic [13:0] exp_q[$];

`ifdef BCD_ERR_CHECK_EN
  localparam logic EXP_BAD_ERR = 1'b1;
`else
  localparam logic EXP_BAD_ERR = 1'b0;
`endif

  bcd_binary_seq_ctrl #(.DIGITS(4), .BIN_W(14)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .bcd_in    (bcd_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .bin_out   (bin_out),
    .err       (err)
  );

  bcd_binary_seq_ctrl #(.DIGITS(2), .BIN_W(7)) dut2 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid2),
    .in_ready  (in_ready2),
    .bcd_in    (bcd_in2),
    .out_valid (out_valid2),
    .out_ready (out_ready2),
    .bin_out   (bin_out2),
    .err       (err2)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Drivers
  task automatic send(input logic [15:0] w, input logic [13:0] exp);
    chk("in_ready_before_send", 32'(in_ready), 32'd1);
    bcd_in   = w;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    exp_q.push_back(exp);
  endtask

  // Scoreboard: waits for out_valid, checks latency, value and err.
  task automatic collect(input string tag, input logic exp_err);
    int n;
    logic [13:0] e;
    n = 0;
    while (!out_valid && n < 40) begin
      chk({tag, "_in_ready_busy"}, 32'(in_ready), 32'd0);
      step();
      n++;
    end
    chk({tag, "_latency"}, 32'(n), 32'd4);
    if (exp_q.size() == 0) begin
      chk({tag, "_scoreboard_empty"}, 32'(exp_q.size()), 32'd1);
    end else begin
      e = exp_q.pop_front();
      chk({tag, "_bin_out"}, 32'(bin_out), 32'(e));
    end
    chk({tag, "_err"}, 32'(err), 32'(exp_err));
    chk({tag, "_in_ready_done"}, 32'(in_ready), 32'd0);
  endtask

  task automatic release_out(input string tag);
    out_ready = 1'b1;
    step();
    chk({tag, "_out_valid_drop"}, 32'(out_valid), 32'd0);
    chk({tag, "_in_ready_back"}, 32'(in_ready), 32'd1);
  endtask

  task automatic run2(input string tag, input logic [7:0] w, input logic [6:0] exp, input logic exp_err);
    bcd_in2   = w;
    in_valid2 = 1'b1;
    out_ready2 = 1'b1;
    step();
    in_valid2 = 1'b0;
    step();
    chk({tag, "_early"}, 32'(out_valid2), 32'd0);
    step();
    chk({tag, "_out_valid"}, 32'(out_valid2), 32'd1);
    chk({tag, "_bin_out"}, 32'(bin_out2), 32'(exp));
    chk({tag, "_err"}, 32'(err2), 32'(exp_err));
    step();
    chk({tag, "_drop"}, 32'(out_valid2), 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0; bcd_in = '0; out_ready = 1'b1;
    in_valid2 = 1'b0; bcd_in2 = '0; out_ready2 = 1'b1;
    step();
    step();
    rst = 1'b0;

    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_bin_out", 32'(bin_out), 32'd0);
    chk("rst_err", 32'(err), 32'd0);

    // 9999 with consumer ready
    send(16'h9999, 14'd9999);
    collect("w9999", 1'b0);
    release_out("w9999");

    // Back-to-back 0000 then 0001
    send(16'h0000, 14'd0);
    collect("w0000", 1'b0);
    release_out("w0000");
    send(16'h0001, 14'd1);
    collect("w0001", 1'b0);
    release_out("w0001");

    // Back-pressure: hold DONE for 10 cycles, with a competing word offered
    out_ready = 1'b0;
    send(16'h1234, 14'd1234);
    collect("w1234", 1'b0);
    bcd_in   = 16'h7777;
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("hold_out_valid", 32'(out_valid), 32'd1);
      chk("hold_bin_out", 32'(bin_out), 32'd1234);
      chk("hold_in_ready", 32'(in_ready), 32'd0);
    end
    in_valid = 1'b0;
    release_out("w1234");

    // Non-decimal digit: 1*1000 + 2*100 + 10*10 + 4
    send(16'h12A4, 14'd1304);
    collect("w12a4", EXP_BAD_ERR);
    release_out("w12a4");

    // Reset two cycles into a conversion abandons it
    send(16'h5678, 14'd5678);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    exp_q.delete();
    chk("abort_in_ready", 32'(in_ready), 32'd1);
    chk("abort_out_valid", 32'(out_valid), 32'd0);
    chk("abort_bin_out", 32'(bin_out), 32'd0);
    for (int i = 0; i < 6; i++) begin
      step();
      chk("abort_no_out_valid", 32'(out_valid), 32'd0);
    end
    send(16'h0042, 14'd42);
    collect("w0042", 1'b0);
    release_out("w0042");

    // Two-digit instance, including a wrapping non-decimal word: 15*10+15 = 165 mod 128
    run2("d2_99", 8'h99, 7'd99, 1'b0);
    run2("d2_ff", 8'hFF, 7'd37, EXP_BAD_ERR);
    run2("d2_07", 8'h07, 7'd7, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
